// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a 32-bit word stream into 512-bit blocks, appends FIPS 180-4
// padding and chains blocks through the compressor. Optional abort input: SHA256_PAD_ABORT_EN.
module sha256_msg_padder #(
    parameter int unsigned  LEN_W = 64,
    parameter logic [255:0] IV    =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    output logic [511:0] msg_block,
    output logic [255:0] initial_hash,
    output logic         blk_start,
    input  logic         blk_ready,
    input  logic         blk_done,
    input  logic [255:0] hash_in,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
`ifdef SHA256_PAD_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [2:0] {StIdle, StFill, StPad, StIssue, StWait} state_t;

    state_t             state_q;
    logic [31:0]        words_q [16];
    logic [4:0]         widx_q;
    logic [LEN_W-1:0]   bit_cnt_q;
    logic [255:0]       chain_q;
    logic               last_blk_q;
    logic               extra_q;
    logic               pend_q;
    logic               drop_q;

    logic               abort_req;
    logic               accept;
    logic [2:0]         eff_bytes;
    logic [4:0]         idx;
    logic [3:0]         idx4;
    logic [31:0]        last_word;
    logic [LEN_W-1:0]   add_bits;

`ifdef SHA256_PAD_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign in_ready     = (state_q == StIdle) || (state_q == StFill);
    assign busy         = (state_q != StIdle);
    assign initial_hash = chain_q;
    assign accept       = in_valid && in_ready;
    assign eff_bytes    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign idx          = (state_q == StIdle) ? 5'd0 : widx_q;
    assign idx4         = idx[3:0];
    assign add_bits     = LEN_W'({eff_bytes, 3'b000});

    // Final partial word: keep the valid leading bytes, then the 0x80 marker, then zeros.
    always_comb begin
        last_word = in_data;
        unique case (eff_bytes)
            3'd1:    last_word = {in_data[31:24], 24'h800000};
            3'd2:    last_word = {in_data[31:16], 16'h8000};
            3'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase
    end

    always_comb begin
        msg_block = '0;
        for (int i = 0; i < 16; i++) begin
            msg_block[511 - 32*i -: 32] = words_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            widx_q       <= '0;
            bit_cnt_q    <= '0;
            chain_q      <= IV;
            last_blk_q   <= 1'b0;
            extra_q      <= 1'b0;
            pend_q       <= 1'b0;
            drop_q       <= 1'b0;
            blk_start    <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
            for (int i = 0; i < 16; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            blk_start    <= 1'b0;
            digest_valid <= 1'b0;
            if (abort_req && (state_q == StFill || state_q == StPad || state_q == StIssue)) begin
                state_q    <= StIdle;
                widx_q     <= '0;
                chain_q    <= IV;
                last_blk_q <= 1'b0;
                extra_q    <= 1'b0;
                pend_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StFill: begin
                        if (accept) begin
                            bit_cnt_q  <= ((state_q == StIdle) ? '0 : bit_cnt_q) + add_bits;
                            last_blk_q <= 1'b0;
                            extra_q    <= 1'b0;
                            drop_q     <= 1'b0;
                            if (!in_last) begin
                                words_q[idx4] <= in_data;
                                widx_q        <= idx + 5'd1;
                                state_q       <= (idx == 5'd15) ? StIssue : StFill;
                            end else if (eff_bytes == 3'd0) begin
                                words_q[idx4] <= 32'h8000_0000;
                                widx_q        <= idx + 5'd1;
                                state_q       <= StPad;
                            end else if (eff_bytes == 3'd4) begin
                                words_q[idx4] <= in_data;
                                // A full last word in slot 15 pushes the marker into the next block.
                                if (idx == 5'd15) begin
                                    pend_q <= 1'b1;
                                    widx_q <= 5'd16;
                                end else begin
                                    words_q[idx4 + 4'd1] <= 32'h8000_0000;
                                    widx_q               <= idx + 5'd2;
                                end
                                state_q <= StPad;
                            end else begin
                                words_q[idx4] <= last_word;
                                widx_q        <= idx + 5'd1;
                                state_q       <= StPad;
                            end
                        end
                    end
                    StPad: begin
                        if (widx_q < 5'd14) begin
                            words_q[widx_q[3:0]] <= '0;
                            widx_q               <= widx_q + 5'd1;
                        end else if (widx_q == 5'd14) begin
                            words_q[14] <= bit_cnt_q[63:32];
                            words_q[15] <= bit_cnt_q[31:0];
                            widx_q      <= 5'd16;
                            last_blk_q  <= 1'b1;
                            state_q     <= StIssue;
                        end else begin
                            // No room for the length: close this block, length goes in an extra one.
                            if (widx_q == 5'd15) begin
                                words_q[15] <= '0;
                            end
                            widx_q     <= 5'd16;
                            last_blk_q <= 1'b0;
                            extra_q    <= 1'b1;
                            state_q    <= StIssue;
                        end
                    end
                    StIssue: begin
                        if (blk_ready) begin
                            blk_start <= 1'b1;
                            state_q   <= StWait;
                        end
                    end
                    StWait: begin
                        if (abort_req) begin
                            drop_q <= 1'b1;
                        end
                        if (blk_done) begin
                            widx_q <= '0;
                            if (drop_q || abort_req) begin
                                drop_q     <= 1'b0;
                                chain_q    <= IV;
                                last_blk_q <= 1'b0;
                                extra_q    <= 1'b0;
                                pend_q     <= 1'b0;
                                state_q    <= StIdle;
                            end else if (last_blk_q) begin
                                digest       <= hash_in;
                                digest_valid <= 1'b1;
                                chain_q      <= IV;
                                last_blk_q   <= 1'b0;
                                state_q      <= StIdle;
                            end else if (extra_q) begin
                                chain_q <= hash_in;
                                extra_q <= 1'b0;
                                if (pend_q) begin
                                    words_q[0] <= 32'h8000_0000;
                                    widx_q     <= 5'd1;
                                    pend_q     <= 1'b0;
                                end
                                state_q <= StPad;
                            end else begin
                                chain_q <= hash_in;
                                state_q <= StFill;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
